// File: rtl/synfull_delivery_collector.sv
// synfull_delivery_collector
// Ejection-side buffer between a packet injector's delivery strobe and the
// SynFull traffic model. The injector cannot be stalled, so delivered-packet
// records go into a first-word-fall-through FIFO. They leave over a
// valid/ready handshake, each tagged with how long it has been buffered.
// The block keeps receive statistics and runs a drain/quiescence FSM that
// reports when the endpoint has gone idle after injection ends.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; deliveries are strays and are not stored
// ST_RUN   | traffic active; deliveries are buffered
// ST_DRAIN | injection ended; counting consecutive quiet cycles
// ST_DONE  | endpoint quiescent; held until reset
module synfull_delivery_collector #(
    parameter int IDw          = 32,
    parameter int SIZw         = 4,
    parameter int SRCw         = 4,
    parameter int DEPTH        = 8,
    parameter int TSw          = 32,
    parameter int QUIET_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   end_i,
    input  logic                   del_valid_i,
    input  logic [IDw-1:0]         del_id_i,
    input  logic [SIZw-1:0]        del_size_i,
    input  logic [SRCw-1:0]        del_src_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [IDw-1:0]         out_id_o,
    output logic [SIZw-1:0]        out_size_o,
    output logic [SRCw-1:0]        out_src_o,
    output logic [TSw-1:0]         out_wait_o,
    output logic [63:0]            rcv_pck_cnt_o,
    output logic [63:0]            rcv_flit_cnt_o,
    output logic [31:0]            drop_cnt_o,
    output logic [31:0]            stray_cnt_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] max_occ_o,
    output logic [1:0]             state_o,
    output logic                   done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [QW-1:0] QUIET_C = QW'(QUIET_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic            done_q;
    logic [QW-1:0]   quiet_q;
    logic [QW-1:0]   quiet_inc;

    logic [TSw-1:0]  ts_q;

    logic [IDw-1:0]  id_mem_q   [DEPTH];
    logic [SIZw-1:0] size_mem_q [DEPTH];
    logic [SRCw-1:0] src_mem_q  [DEPTH];
    logic [TSw-1:0]  ts_mem_q   [DEPTH];

    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   max_occ_q;
    logic [CW-1:0]   max_occ_d;

    logic [63:0]     rcv_pck_q;
    logic [63:0]     rcv_flit_q;
    logic [31:0]     drop_q;
    logic [31:0]     stray_q;
    logic            overflow_q;

    logic            fifo_valid;
    logic            pop;
    logic            active;
    logic            accept;
    logic            drop;
    logic            stray;

    // Handshake, accept/drop/stray classification and next occupancy.
    // A full FIFO still takes a delivery when the head leaves the same cycle.
    always_comb begin
        fifo_valid = (count_q != '0);
        pop        = fifo_valid && out_ready_i;
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        accept     = active && del_valid_i && ((count_q != DEPTH_C) || pop);
        drop       = active && del_valid_i && !accept;
        stray      = !active && del_valid_i;
        count_d    = count_q + CW'(accept) - CW'(pop);
        max_occ_d  = (count_d > max_occ_q) ? count_d : max_occ_q;
        quiet_inc  = quiet_q + QW'(1);
    end

    // Head record presentation; fields read as zero whenever the FIFO is empty.
    always_comb begin
        out_valid_o = fifo_valid;
        out_id_o    = '0;
        out_size_o  = '0;
        out_src_o   = '0;
        out_wait_o  = '0;
        if (fifo_valid) begin
            out_id_o   = id_mem_q[rd_ptr_q];
            out_size_o = size_mem_q[rd_ptr_q];
            out_src_o  = src_mem_q[rd_ptr_q];
            out_wait_o = ts_q - ts_mem_q[rd_ptr_q];
        end
    end

    // Record storage; stale contents after reset are harmless since the pointers clear.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            id_mem_q[wr_ptr_q]   <= del_id_i;
            size_mem_q[wr_ptr_q] <= del_size_i;
            src_mem_q[wr_ptr_q]  <= del_src_i;
            ts_mem_q[wr_ptr_q]   <= ts_q;
        end
    end

    // FIFO pointers, occupancy, peak occupancy and the free-running timestamp.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            max_occ_q <= '0;
            ts_q      <= '0;
        end else begin
            ts_q      <= ts_q + TSw'(1);
            count_q   <= count_d;
            max_occ_q <= max_occ_d;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Receive statistics; the 64-bit totals wrap, the 32-bit loss counters saturate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcv_pck_q  <= '0;
            rcv_flit_q <= '0;
            drop_q     <= '0;
            stray_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                rcv_pck_q  <= rcv_pck_q + 64'd1;
                rcv_flit_q <= rcv_flit_q + 64'(del_size_i);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + 32'd1;
                end
            end
            if (stray && (stray_q != '1)) begin
                stray_q <= stray_q + 32'd1;
            end
        end
    end

    // Sequencing FSM. A quiet DRAIN cycle has no delivery and leaves the FIFO
    // empty after this cycle's pop; anything else restarts the quiet count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            quiet_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    quiet_q <= '0;
                    if (start_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    quiet_q <= '0;
                    if (end_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!del_valid_i && (count_d == '0)) begin
                        quiet_q <= quiet_inc;
                        if (quiet_inc == QUIET_C) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        quiet_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rcv_pck_cnt_o  = rcv_pck_q;
    assign rcv_flit_cnt_o = rcv_flit_q;
    assign drop_cnt_o     = drop_q;
    assign stray_cnt_o    = stray_q;
    assign overflow_o     = overflow_q;
    assign max_occ_o      = max_occ_q;
    assign state_o        = state_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_synfull_delivery_collector.sv
// Bench for synfull_delivery_collector: queue-based reference model,
// scoreboard fed by the driver, and an independent output monitor.
module tb_synfull_delivery_collector;

    localparam int DEPTH = 8;
    localparam int Q     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0, end_i = 1'b0;
    logic        del_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] del_id_i = '0;
    logic [3:0]  del_size_i = '0, del_src_i = '0;
    logic        out_valid_o;
    logic [31:0] out_id_o, out_wait_o, drop_cnt_o, stray_cnt_o;
    logic [3:0]  out_size_o, out_src_o, max_occ_o;
    logic [63:0] rcv_pck_cnt_o, rcv_flit_cnt_o;
    logic        overflow_o, done_o;
    logic [1:0]  state_o;

    synfull_delivery_collector dut (
        .clk(clk), .reset(reset), .start_i(start_i), .end_i(end_i),
        .del_valid_i(del_valid_i), .del_id_i(del_id_i), .del_size_i(del_size_i),
        .del_src_i(del_src_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_id_o(out_id_o), .out_size_o(out_size_o), .out_src_o(out_src_o),
        .out_wait_o(out_wait_o), .rcv_pck_cnt_o(rcv_pck_cnt_o),
        .rcv_flit_cnt_o(rcv_flit_cnt_o), .drop_cnt_o(drop_cnt_o),
        .stray_cnt_o(stray_cnt_o), .overflow_o(overflow_o), .max_occ_o(max_occ_o),
        .state_o(state_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] id;
        logic [3:0]  sz;
        logic [3:0]  src;
        int          t;
    } rec_t;

    rec_t sb[$];

    int              m_occ, m_state, m_quiet, m_max;
    longint unsigned m_rcv, m_flit;
    int unsigned     m_drop, m_stray;
    bit              m_ovf;
    bit              exp_valid = 1'b0;
    int              vectors = 0;
    int              errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_occ = 0; m_state = 0; m_quiet = 0; m_max = 0;
        m_rcv = 0; m_flit = 0; m_drop = 0; m_stray = 0; m_ovf = 0;
        sb.delete();
        exp_valid = 1'b0;
    endtask

    task automatic rst();
        reset = 1'b0;
        del_valid_i = 0; start_i = 0; end_i = 0; out_ready_i = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
    endtask

    // Applies one cycle of stimulus and advances the reference model.
    task automatic step(input bit dv, input logic [31:0] id, input logic [3:0] sz,
                        input bit rdy, input bit st, input bit en);
        bit          pop, acc;
        logic [3:0]  src;
        src = 4'($urandom);
        del_valid_i = dv; del_id_i = id; del_size_i = sz; del_src_i = src;
        out_ready_i = rdy; start_i = st; end_i = en;
        exp_valid = (m_occ > 0);
        pop = exp_valid && rdy;
        acc = 0;
        if (dv) begin
            if (m_state == 1 || m_state == 2) begin
                if (m_occ < DEPTH || pop) begin
                    acc = 1;
                    sb.push_back('{id, sz, src, cyc});
                    m_rcv++;
                    m_flit += 64'(sz);
                end else begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                    m_ovf = 1;
                end
            end else if (m_stray != 32'hFFFF_FFFF) begin
                m_stray++;
            end
        end
        m_occ = m_occ - int'(pop) + int'(acc);
        if (m_occ > m_max) m_max = m_occ;
        case (m_state)
            0: if (st) m_state = 1;
            1: if (en) m_state = 2;
            2: begin
                if (!dv && m_occ == 0) m_quiet++;
                else m_quiet = 0;
                if (m_quiet == Q) m_state = 3;
            end
            default: ;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic rnd_step(input bit dv, input bit rdy);
        step(dv, $urandom, 4'($urandom), rdy, 1'b0, 1'b0);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_rcv"},   rcv_pck_cnt_o, m_rcv);
        chk({tag, "_flit"},  rcv_flit_cnt_o, m_flit);
        chk({tag, "_drop"},  64'(drop_cnt_o), 64'(m_drop));
        chk({tag, "_stray"}, 64'(stray_cnt_o), 64'(m_stray));
        chk({tag, "_ovf"},   64'(overflow_o), 64'(m_ovf));
        chk({tag, "_max"},   64'(max_occ_o), 64'(m_max));
        chk({tag, "_state"}, 64'(state_o), 64'(m_state));
        chk({tag, "_done"},  64'(done_o), 64'(m_state == 3));
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && m_occ != 0; g++) rnd_step(1'b0, 1'b1);
        chk("drain_empty", 64'(m_occ), 64'd0);
    endtask

    // Scoreboard monitor: checks valid every cycle and every completed pop.
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL pop_unexpected: got id %0h expected no record", out_id_o);
                end else begin
                    rec_t r;
                    r = sb.pop_front();
                    chk("out_id",   64'(out_id_o), 64'(r.id));
                    chk("out_size", 64'(out_size_o), 64'(r.sz));
                    chk("out_src",  64'(out_src_o), 64'(r.src));
                    chk("out_wait", 64'(out_wait_o), 64'(32'(cyc - r.t)));
                end
            end
        end
    end

    initial begin
        model_clear();
        @(posedge clk); #1;
        rst();
        // Reset state
        check_counters("reset");
        chk("reset_id", 64'(out_id_o), 64'd0);
        chk("reset_wait", 64'(out_wait_o), 64'd0);

        // Delivery before start is a stray
        rnd_step(1'b1, 1'b1);
        check_counters("stray");
        chk("stray_cnt1", 64'(stray_cnt_o), 64'd1);

        // Start, then A/B/C back to back with ready high
        step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'hA, 4'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 4'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hC, 4'd4, 1'b1, 1'b0, 1'b0);
        drain();
        check_counters("abc");
        chk("abc_pck", rcv_pck_cnt_o, 64'd3);
        chk("abc_flit", rcv_flit_cnt_o, 64'd9);

        // Overflow: ten deliveries into a stalled FIFO
        repeat (10) rnd_step(1'b1, 1'b0);
        check_counters("ovf");
        chk("ovf_drop2", 64'(drop_cnt_o), 64'd2);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_max8", 64'(max_occ_o), 64'd8);

        // Full FIFO with simultaneous delivery and pop
        rnd_step(1'b1, 1'b1);
        chk("fullpop_drop", 64'(drop_cnt_o), 64'd2);
        chk("fullpop_valid", 64'(out_valid_o), 64'd1);
        chk("fullpop_occ", 64'(m_occ), 64'd8);
        drain();
        check_counters("fullpop");

        // Randomized traffic in RUN
        for (int i = 0; i < 1500; i++)
            rnd_step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
        drain();
        check_counters("random");

        // Head held for five cycles with ready low
        begin
            logic [31:0] hid;
            hid = $urandom;
            step(1'b1, hid, 4'd5, 1'b0, 1'b0, 1'b0);
            for (int i = 1; i <= 5; i++) begin
                chk("hold_id", 64'(out_id_o), 64'(hid));
                chk("hold_wait", 64'(out_wait_o), 64'(i));
                rnd_step(1'b0, 1'b0);
            end
            rnd_step(1'b0, 1'b1);
        end

        // Drain sequence with a late delivery restarting the quiet count
        repeat (3) rnd_step(1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        for (int g = 0; g < 40 && m_quiet != 10; g++) rnd_step(1'b0, 1'b1);
        chk("drain_state", 64'(state_o), 64'd2);
        rnd_step(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_notdone", 64'(done_o), 64'd0);
            rnd_step(1'b0, 1'b1);
        end
        chk("drain_done", 64'(done_o), 64'd1);
        chk("drain_state3", 64'(state_o), 64'd3);
        rnd_step(1'b1, 1'b1);
        check_counters("done");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of RUN with four records buffered
        rst();
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        repeat (4) rnd_step(1'b1, 1'b0);
        chk("mid_valid", 64'(out_valid_o), 64'd1);
        rst();
        check_counters("midrst");
        chk("midrst_state", 64'(state_o), 64'd0);
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_pck", rcv_pck_cnt_o, 64'd0);
        repeat (2) rnd_step(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
